shared_reg_arbiter: RTL and testbench

Round-robin arbiter and sequencer for one shared WIDTH-bit storage register, built from the team's flip-flop cells, that NREQ requesters write into. It grants ownership to one requester at a time and accepts that owner's write strobes. It forces release after a bounded hold and inserts a one-cycle turnaround between owners. It sits between the requester ports and the shared state register in the datapath.

---
 rtl/shared_reg_pkg.sv | 18 +
 rtl/shared_reg_arbiter_rr_pick.sv | 29 ++
 rtl/shared_reg_arbiter.sv | 132 +++++++++++++
 tb/tb_shared_reg_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/shared_reg_pkg.sv
// Shared types and sizing helpers for the shared-register arbiter.
package shared_reg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWNED = 2'd1,
      TURN  = 2'd2
   } state_t;

   localparam int unsigned NREQ_DEF     = 4;
   localparam int unsigned MAX_HOLD_DEF = 16;

   // Index width for a population of n items; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit at or after ptr, wrapping.
module rr_pick
   import shared_reg_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned IW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic            valid,
   output logic [IW-1:0]   index
);

   logic [IW-1:0] cand;

   always_comb begin
      valid = 1'b0;
      index = '0;
      cand  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = (32'(ptr) + k >= NREQ) ? IW'(32'(ptr) + k - NREQ) : IW'(32'(ptr) + k);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin owner arbitration and write sequencing for one shared register.
// Optional forced release after MAX_HOLD cycles: define SHARED_REG_TIMEOUT_EN.
module shared_reg_arbiter
   import shared_reg_pkg::*;
#(
   parameter int unsigned NREQ     = NREQ_DEF,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
   localparam int unsigned IW      = idx_w(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       we,
   input  logic [NREQ*WIDTH-1:0] wdata,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      q,
   output logic                  busy,
   output logic [IW-1:0]         owner_id,
   output logic                  timeout
);

   state_t          state, state_n;
   logic [NREQ-1:0] gnt_n;
   logic [WIDTH-1:0] q_n;
   logic            busy_n;
   logic [IW-1:0]   owner_n, ptr, ptr_n;
   logic [IW-1:0]   turn_ptr, pick_ptr, pick_idx;
   logic            pick_valid;

`ifdef SHARED_REG_TIMEOUT_EN
   localparam int unsigned HW = idx_w(MAX_HOLD);
   logic [HW-1:0] hold, hold_n;
   logic          timeout_n;
`else
   logic unused_max_hold;
   assign unused_max_hold = (MAX_HOLD != 0);
   assign timeout         = 1'b0;
`endif

   // The released owner drops to lowest priority; TURN arbitrates from there directly.
   assign turn_ptr = (owner_id == IW'(NREQ - 1)) ? '0 : owner_id + IW'(1);
   assign pick_ptr = (state == TURN) ? turn_ptr : ptr;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req   (req),
      .ptr   (pick_ptr),
      .valid (pick_valid),
      .index (pick_idx)
   );

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      q_n     = q;
      busy_n  = busy;
      owner_n = owner_id;
      ptr_n   = ptr;
`ifdef SHARED_REG_TIMEOUT_EN
      hold_n    = hold;
      timeout_n = 1'b0;
`endif
      case (state)
         IDLE, TURN: begin
            if (state == TURN) ptr_n = turn_ptr;
            if (pick_valid) begin
               gnt_n   = NREQ'(1) << pick_idx;
               owner_n = pick_idx;
               busy_n  = 1'b1;
               state_n = OWNED;
`ifdef SHARED_REG_TIMEOUT_EN
               hold_n  = '0;
`endif
            end else begin
               state_n = IDLE;
            end
         end
         OWNED: begin
            // Writes are qualified by ownership, so a write in the release cycle still lands.
            if (we[owner_id]) q_n = wdata[32'(owner_id) * WIDTH +: WIDTH];
`ifdef SHARED_REG_TIMEOUT_EN
            hold_n = hold + HW'(1);
`endif
            if (!req[owner_id]) begin
               gnt_n   = '0;
               busy_n  = 1'b0;
               state_n = TURN;
            end
`ifdef SHARED_REG_TIMEOUT_EN
            else if (hold == HW'(MAX_HOLD - 1)) begin
               gnt_n     = '0;
               busy_n    = 1'b0;
               timeout_n = 1'b1;
               state_n   = TURN;
            end
`endif
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
            busy_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         gnt      <= '0;
         q        <= '0;
         busy     <= 1'b0;
         owner_id <= '0;
         ptr      <= '0;
`ifdef SHARED_REG_TIMEOUT_EN
         hold     <= '0;
         timeout  <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         gnt      <= gnt_n;
         q        <= q_n;
         busy     <= busy_n;
         owner_id <= owner_n;
         ptr      <= ptr_n;
`ifdef SHARED_REG_TIMEOUT_EN
         hold     <= hold_n;
         timeout  <= timeout_n;
`endif
      end
   end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: grant order, writes, release, reset and hold limit.
module tb_shared_reg_arbiter;

   localparam int unsigned NREQ     = 4;
   localparam int unsigned WIDTH    = 8;
   localparam int unsigned MAX_HOLD = 16;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       we;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       gnt;
   logic [WIDTH-1:0]      q;
   logic                  busy;
   logic [1:0]            owner_id;
   logic                  timeout;

   int total = 0;
   int bad   = 0;
   int order [5] = '{0, 1, 2, 3, 0};

   shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .we       (we),
      .wdata    (wdata),
      .gnt      (gnt),
      .q        (q),
      .busy     (busy),
      .owner_id (owner_id),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      req   = '0;
      we    = '0;
      wdata = '0;
      reset = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req   = '0;
      we    = '0;
      wdata = '0;
      tick();
      tick();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=%b", gnt, 4'b0000); end
      total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h want=%h", q, 8'h00); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (owner_id !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d want=0", owner_id); end
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout); end
      reset = 1'b1;
      tick();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL idle_no_req got=%b want=%b", gnt, 4'b0000); end
   endtask

   task automatic test_pick_release();
      req = 4'b0110;
      tick();
      total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL pick_gnt got=%b want=%b", gnt, 4'b0010); end
      total++; if (owner_id !== 2'd1) begin bad++; $display("FAIL pick_owner got=%0d want=1", owner_id); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL pick_busy got=%b want=1", busy); end
      req = 4'b0100;
      tick();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL turn_gnt got=%b want=%b", gnt, 4'b0000); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL turn_busy got=%b want=0", busy); end
      total++; if (owner_id !== 2'd1) begin bad++; $display("FAIL turn_owner_kept got=%0d want=1", owner_id); end
      tick();
      total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL next_gnt got=%b want=%b", gnt, 4'b0100); end
      total++; if (owner_id !== 2'd2) begin bad++; $display("FAIL next_owner got=%0d want=2", owner_id); end
   endtask

   task automatic test_write_owner();
      we    = 4'b0101;
      wdata = {8'h00, 8'h3C, 8'h00, 8'hFF};
      tick();
      total++; if (q !== 8'h3C) begin bad++; $display("FAIL owner_write got=%h want=%h", q, 8'h3C); end
      we = 4'b0001;
      tick();
      total++; if (q !== 8'h3C) begin bad++; $display("FAIL nonowner_ignored got=%h want=%h", q, 8'h3C); end
      total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL owner_kept got=%b want=%b", gnt, 4'b0100); end
   endtask

   task automatic test_drop_with_write();
      req   = 4'b0000;
      we    = 4'b0100;
      wdata = {8'h00, 8'h5A, 8'h00, 8'h00};
      tick();
      total++; if (q !== 8'h5A) begin bad++; $display("FAIL drop_write_q got=%h want=%h", q, 8'h5A); end
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL drop_gnt got=%b want=%b", gnt, 4'b0000); end
      we    = '0;
      wdata = {8'h11, 8'h22, 8'h33, 8'h44};
      tick();
      tick();
      total++; if (q !== 8'h5A) begin bad++; $display("FAIL idle_q_hold got=%h want=%h", q, 8'h5A); end
      total++; if (owner_id !== 2'd2) begin bad++; $display("FAIL idle_owner_kept got=%0d want=2", owner_id); end
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL idle_gnt got=%b want=%b", gnt, 4'b0000); end
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] exp_gnt;
      pulse_reset();
      tick();
      req = 4'b1111;
      tick();
      for (int i = 0; i < 5; i++) begin
         exp_gnt = 4'b0001 << order[i];
         total++; if (gnt !== exp_gnt) begin bad++; $display("FAIL rr_gnt_%0d got=%b want=%b", i, gnt, exp_gnt); end
         total++; if (owner_id !== 2'(order[i])) begin bad++; $display("FAIL rr_owner_%0d got=%0d want=%0d", i, owner_id, order[i]); end
         req = 4'b1111 & ~exp_gnt;
         tick();
         total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rr_gap_%0d got=%b want=%b", i, gnt, 4'b0000); end
         req = 4'b1111;
         tick();
      end
      req = '0;
      tick();
      tick();
   endtask

   task automatic test_reset_mid_owned();
      pulse_reset();
      tick();
      req = 4'b0001;
      tick();
      we    = 4'b0001;
      wdata = {8'h00, 8'h00, 8'h00, 8'hA5};
      tick();
      we = '0;
      total++; if (q !== 8'hA5) begin bad++; $display("FAIL pre_reset_q got=%h want=%h", q, 8'hA5); end
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL pre_reset_gnt got=%b want=%b", gnt, 4'b0001); end
      #2;
      reset = 1'b0;
      #1;
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL async_reset_gnt got=%b want=%b", gnt, 4'b0000); end
      total++; if (q !== 8'h00) begin bad++; $display("FAIL async_reset_q got=%h want=%h", q, 8'h00); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_reset_busy got=%b want=0", busy); end
      req = '0;
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_hold_limit();
      pulse_reset();
      tick();
      req = 4'b0011;
      tick();
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL hold_first_gnt got=%b want=%b", gnt, 4'b0001); end
      for (int i = 1; i < 16; i++) begin
         tick();
         total++; if (gnt !== 4'b0001 || timeout !== 1'b0) begin
            bad++; $display("FAIL hold_cycle_%0d gnt=%b timeout=%b want gnt=0001 timeout=0", i, gnt, timeout);
         end
      end
      tick();
`ifdef SHARED_REG_TIMEOUT_EN
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL forced_release_gnt got=%b want=%b", gnt, 4'b0000); end
      total++; if (timeout !== 1'b1) begin bad++; $display("FAIL timeout_pulse got=%b want=1", timeout); end
      tick();
      total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL after_timeout_gnt got=%b want=%b", gnt, 4'b0010); end
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_one_cycle got=%b want=0", timeout); end
`else
      for (int i = 0; i < 4; i++) begin
         total++; if (gnt !== 4'b0001 || timeout !== 1'b0) begin
            bad++; $display("FAIL no_timeout_%0d gnt=%b timeout=%b want gnt=0001 timeout=0", i, gnt, timeout);
         end
         tick();
      end
`endif
      req = '0;
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_pick_release();
      test_write_owner();
      test_drop_with_write();
      test_round_robin();
      test_reset_mid_owned();
      test_hold_limit();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
